// File: rtl/note_input_encoder.sv
// Piano key front-end: synchronises and debounces note/octave keys, then drives a
// last-pressed-wins note selector, a saturating octave register and note_on/note_off pulses.
module note_input_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned OCTAVE_RESET    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] note_btn,
    input  logic       oct_up,
    input  logic       oct_down,
    output logic [2:0] note,
    output logic [2:0] octave,
    output logic       note_on,
    output logic       note_off
);

    localparam int unsigned N  = 9;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic {
        IDLE,
        PLAYING
    } state_t;

    logic [N-1:0]  raw;
    logic [N-1:0]  sync1_q, sync2_q;
    logic [N-1:0]  stable_q, stable_d;
    logic [N-1:0]  press, rel_ev;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    state_t     state_q, state_d;
    logic [2:0] note_q, note_d;
    logic [2:0] octave_q, octave_d;
    logic       note_on_q, note_on_d;
    logic       note_off_q, note_off_d;
    logic [6:0] cur_mask;
    logic [6:0] new_press;

    assign raw = {oct_down, oct_up, note_btn};

    // Returns the note code (index + 1) of the lowest set key, 0 when none.
    function automatic logic [2:0] lowest_code(input logic [6:0] v);
        logic [2:0] r;
        r = '0;
        for (int unsigned i = 7; i > 0; i--) begin
            if (v[i-1]) r = 3'(i);
        end
        return r;
    endfunction

    always_comb begin
        stable_d = stable_q;
        press    = '0;
        rel_ev   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = ~stable_q[i];
                cnt_d[i]    = '0;
                press[i]    = ~stable_q[i];
                rel_ev[i]   = stable_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        octave_d   = octave_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        cur_mask   = (state_q == PLAYING) ? (7'b1 << (note_q - 3'd1)) : '0;
        new_press  = press[6:0] & ~cur_mask;

        // A fresh press always wins, even when the current key is released in the same cycle.
        if (new_press != '0) begin
            state_d   = PLAYING;
            note_d    = lowest_code(new_press);
            note_on_d = 1'b1;
        end else if (state_q == PLAYING && (rel_ev[6:0] & cur_mask) != '0) begin
            if (stable_d[6:0] != '0) begin
                note_d    = lowest_code(stable_d[6:0]);
                note_on_d = 1'b1;
            end else begin
                state_d    = IDLE;
                note_d     = '0;
                note_off_d = 1'b1;
            end
        end

        if (press[7] && !press[8] && octave_q != 3'd7) begin
            octave_d = octave_q + 3'd1;
        end else if (press[8] && !press[7] && octave_q != 3'd0) begin
            octave_d = octave_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
            state_q    <= IDLE;
            note_q     <= '0;
            octave_q   <= 3'(OCTAVE_RESET);
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
            state_q    <= state_d;
            note_q     <= note_d;
            octave_q   <= octave_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
        end
    end

    assign note     = note_q;
    assign octave   = octave_q;
    assign note_on  = note_on_q;
    assign note_off = note_off_q;

endmodule

// File: tb/tb_note_input_encoder.sv
// Bench for note_input_encoder: directed test-plan scenarios plus random key activity,
// every cycle compared against a run-length based behavioural model.
module tb_note_input_encoder;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] note_btn;
    logic       oct_up;
    logic       oct_down;
    logic [2:0] note;
    logic [2:0] octave;
    logic       note_on;
    logic       note_off;

    always #5 clk = ~clk;

    note_input_encoder #(
        .DEBOUNCE_CYCLES(D),
        .OCTAVE_RESET   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .note_btn(note_btn),
        .oct_up  (oct_up),
        .oct_down(oct_down),
        .note    (note),
        .octave  (octave),
        .note_on (note_on),
        .note_off(note_off)
    );

    int errors  = 0;
    int checks  = 0;
    int on_cnt  = 0;
    int off_cnt = 0;

    // Model: raw samples delayed two edges, then a value is accepted once the
    // debouncer has seen it for D+1 consecutive edges.
    logic [8:0] p1 = '0, p2 = '0, deb = '0, lastv = '0;
    int run [9];
    int m_note = 0, m_oct = 3, m_on = 0, m_off = 0;

    function automatic int lowest_key(input logic [6:0] v);
        for (int i = 0; i < 7; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [8:0] rawv;
        logic [8:0] pr;
        logic [8:0] rl;
        logic [6:0] cur;
        logic [6:0] newp;
        rawv = {oct_down, oct_up, note_btn};
        pr = '0;
        rl = '0;
        if (rst) begin
            p1 = '0; p2 = '0; deb = '0; lastv = '0;
            for (int i = 0; i < 9; i++) run[i] = 1;
            m_note = 0; m_oct = 3; m_on = 0; m_off = 0;
            return;
        end
        for (int i = 0; i < 9; i++) begin
            if (p2[i] == lastv[i]) run[i]++;
            else run[i] = 1;
            lastv[i] = p2[i];
            if (p2[i] != deb[i] && run[i] >= D + 1) begin
                deb[i] = p2[i];
                if (p2[i]) pr[i] = 1'b1;
                else rl[i] = 1'b1;
            end
        end
        p2 = p1;
        p1 = rawv;
        m_on = 0;
        m_off = 0;
        cur = (m_note != 0) ? (7'b1 << (m_note - 1)) : 7'b0;
        newp = pr[6:0] & ~cur;
        if (newp != 0) begin
            m_note = lowest_key(newp) + 1;
            m_on = 1;
        end else if (m_note != 0 && rl[m_note-1]) begin
            if (deb[6:0] != 0) begin
                m_note = lowest_key(deb[6:0]) + 1;
                m_on = 1;
            end else begin
                m_note = 0;
                m_off = 1;
            end
        end
        if (pr[7] && !pr[8] && m_oct < 7) m_oct++;
        else if (pr[8] && !pr[7] && m_oct > 0) m_oct--;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("note", 32'(note), 32'(m_note));
        check("octave", 32'(octave), 32'(m_oct));
        check("note_on", 32'(note_on), 32'(m_on));
        check("note_off", 32'(note_off), 32'(m_off));
        check("on_off_exclusive", 32'(note_on & note_off), 32'd0);
        on_cnt  += int'(note_on);
        off_cnt += int'(note_off);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic oct_pulse(input logic up, input logic dn);
        oct_up = up; oct_down = dn;
        steps(8);
        oct_up = 1'b0; oct_down = 1'b0;
        steps(8);
    endtask

    initial begin
        rst = 1'b1; note_btn = '0; oct_up = 1'b0; oct_down = 1'b0;
        steps(2);
        check("reset_note", 32'(note), 32'd0);
        check("reset_octave", 32'(octave), 32'd3);
        check("reset_pulses", 32'({note_on, note_off}), 32'd0);
        rst = 1'b0;

        // 1: single press / release
        note_btn = 7'b0000100;
        steps(7);
        check("s1_note", 32'(note), 32'd3);
        check("s1_on", 32'(note_on), 32'd1);
        steps(1);
        check("s1_on_drop", 32'(note_on), 32'd0);
        steps(12);
        note_btn = '0;
        steps(7);
        check("s1_off_note", 32'(note), 32'd0);
        check("s1_off", 32'(note_off), 32'd1);
        steps(5);

        // 2: glitch rejection
        on_cnt = 0; off_cnt = 0;
        note_btn = 7'b0000001; steps(3);
        note_btn = '0; steps(12);
        check("s2_short_on", 32'(on_cnt), 32'd0);
        check("s2_short_note", 32'(note), 32'd0);
        note_btn = 7'b0000001; steps(5);
        note_btn = '0; steps(12);
        check("s2_long_on", 32'(on_cnt), 32'd1);
        check("s2_long_off", 32'(off_cnt), 32'd1);

        // 3: last-pressed wins and fallback
        on_cnt = 0; off_cnt = 0;
        note_btn = 7'b0000001; steps(10);
        check("s3_c", 32'(note), 32'd1);
        note_btn = 7'b0100001; steps(10);
        check("s3_a", 32'(note), 32'd6);
        check("s3_two_on", 32'(on_cnt), 32'd2);
        check("s3_no_off", 32'(off_cnt), 32'd0);
        note_btn = 7'b0000001; steps(10);
        check("s3_fallback", 32'(note), 32'd1);
        check("s3_fallback_on", 32'(on_cnt), 32'd3);
        note_btn = '0; steps(10);
        check("s3_idle", 32'(note), 32'd0);
        check("s3_off", 32'(off_cnt), 32'd1);

        // 4: simultaneous press
        on_cnt = 0;
        note_btn = 7'b0010100; steps(10);
        check("s4_note", 32'(note), 32'd3);
        check("s4_one_on", 32'(on_cnt), 32'd1);
        note_btn = '0; steps(10);

        // 5: octave saturation
        for (int i = 0; i < 5; i++) begin
            oct_pulse(1'b1, 1'b0);
            check("s5_up", 32'(octave), (i < 4) ? 32'(4 + i) : 32'd7);
        end
        for (int i = 0; i < 8; i++) oct_pulse(1'b0, 1'b1);
        check("s5_down_floor", 32'(octave), 32'd0);
        oct_pulse(1'b1, 1'b1);
        check("s5_both", 32'(octave), 32'd0);
        note_btn = 7'b0010000; steps(10);
        check("s5_g", 32'(note), 32'd5);
        on_cnt = 0; off_cnt = 0;
        oct_pulse(1'b1, 1'b0);
        check("s5_g_kept", 32'(note), 32'd5);
        check("s5_oct_up", 32'(octave), 32'd1);
        check("s5_no_pulses", 32'(on_cnt + off_cnt), 32'd0);
        note_btn = '0; steps(10);

        // 6: reset mid-note
        note_btn = 7'b0001000; steps(10);
        check("s6_f", 32'(note), 32'd4);
        rst = 1'b1; steps(1);
        check("s6_rst_note", 32'(note), 32'd0);
        check("s6_rst_oct", 32'(octave), 32'd3);
        check("s6_rst_nooff", 32'(note_off), 32'd0);
        rst = 1'b0;
        steps(6);
        check("s6_pre_on", 32'(note_on), 32'd0);
        steps(1);
        check("s6_on", 32'(note_on), 32'd1);
        check("s6_note", 32'(note), 32'd4);
        note_btn = '0; steps(10);

        // random key activity against the model
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) note_btn = 7'($urandom & $urandom);
            oct_up   = ($urandom_range(0, 3) == 0);
            oct_down = ($urandom_range(0, 3) == 0);
            steps($urandom_range(1, 10));
        end
        note_btn = '0; oct_up = 1'b0; oct_down = 1'b0;
        steps(20);
        check("final_idle", 32'(note), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_input_encoder.md
# note_input_encoder

Front-end for the electric piano. It converts raw, asynchronous push-button inputs into the `note`/`octave` code pair consumed by the tone-generating amplifier block. It synchronises and debounces seven note keys and two octave keys, then runs a last-pressed-wins note selector and a saturating octave register. It emits one-cycle `note_on`/`note_off` event pulses.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept an input change (10 ms at 100 MHz); legal range >= 1.
- `OCTAVE_RESET`, default 3: octave value after reset; range 0..7.

- `clk` in 1: system clock (100 MHz).
- `rst` in 1: reset, synchronous, active-high.
- `note_btn` in 7: raw note keys, asynchronous, 1 = pressed. Bit 0 = C, 1 = D, 2 = E, 3 = F, 4 = G, 5 = A, 6 = B.
- `oct_up` in 1: raw octave-up key, asynchronous.
- `oct_down` in 1: raw octave-down key, asynchronous.
- `note` out 3: current note. 0 = none, 1 = C, 2 = D, 3 = E, 4 = F, 5 = G, 6 = A, 7 = B (equals key index + 1).
- `octave` out 3: current octave, 0..7.
- `note_on` out 1: one-cycle pulse in the cycle `note` takes a new nonzero value.
- `note_off` out 1: one-cycle pulse in the cycle `note` returns to 0.

## Operation
- **Synchroniser.** Each of the 9 raw inputs passes through a 2-flop synchroniser.
- **Debouncer.**
  - Each input has a stable-state bit and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised value equals the stable state.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, the stable state flips and the counter clears.
  - Stable 0→1 is a press event. Stable 1→0 is a release event.
- **Note selector states:**
  - IDLE: `note` = 0.
  - PLAYING: `note` = k+1 for the current key k.
- **Transitions, evaluated on the debounced events of one cycle:**
  - IDLE, one or more presses: go to PLAYING with the lowest-index pressed key; pulse `note_on`.
  - PLAYING, press of a different key: switch to that key (lowest index if several); pulse `note_on`; no `note_off`.
  - PLAYING, press of the current key: impossible; no action.
  - PLAYING, release of the current key with other keys still held: switch to the lowest-index held key; pulse `note_on`.
  - PLAYING, release of the current key with no keys held: go to IDLE, `note` = 0; pulse `note_off`.
  - Release of a non-current key: no effect.
  - Release of the current key plus a press of another key in the same cycle: switch to the newly pressed key; `note_on` only.
- **Octave register:**
  - Debounced `oct_up` press: +1, saturating at 7.
  - Debounced `oct_down` press: -1, saturating at 0.
  - Both presses in the same cycle: no change.
  - Octave changes never pulse `note_on`/`note_off` and never alter `note`.
- `note_on` and `note_off` are never high in the same cycle.

## Timing
- **Reset values:**
  - `note` = 0, `octave` = OCTAVE_RESET, `note_on` = `note_off` = 0.
  - All synchroniser flops, stable states and counters = 0.
- **Latency.** A raw input change that stays stable reaches the outputs DEBOUNCE_CYCLES+3 cycles after the first clock edge that samples it: 2 for the synchroniser, DEBOUNCE_CYCLES for the debouncer, 1 for the output register.
- **Glitch rejection.** A raw pulse stable for fewer than DEBOUNCE_CYCLES synchronised cycles produces no event.
- **Outputs.** All outputs are registered; `note`, `octave` and the pulses update on the same edge.
- **Reset mid-operation.** All state returns to reset values in the next cycle, with no `note_off` pulse. A key still held after reset is seen as a new press: `note_on` follows DEBOUNCE_CYCLES+3 cycles after `rst` deasserts.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, OCTAVE_RESET = 3.

1. **Single press and release.** Hold `note_btn[2]` high from cycle 0 → `note` = 3 and `note_on` = 1 at cycle 7, `note_on` = 0 at cycle 8. Release at cycle 20 → `note` = 0 and `note_off` = 1 at cycle 27.
2. **Glitch rejection.** Pulse `note_btn[0]` high for 3 cycles → `note` stays 0, no pulses. A 5-cycle pulse → `note_on` with `note` = 1, then `note_off`.
3. **Last-pressed wins and fallback.**
   - Hold C, then later hold A → `note` = 1, then 6, with two `note_on` pulses and no `note_off`.
   - Release A → `note` = 1 with `note_on`.
   - Release C → `note` = 0 with `note_off`.
4. **Simultaneous press.** `note_btn` = 7'b0010100 in a single cycle → `note` = 3, one `note_on`.
5. **Octave saturation.**
   - 5 debounced `oct_up` presses → `octave` 4,5,6,7,7.
   - 8 `oct_down` presses → ends at 0.
   - `oct_up` and `oct_down` pressed together → unchanged.
   - An octave change while `note` = 5 → `note` stays 5, no pulses.
6. **Reset mid-note.**
   - `note` = 4 held, assert `rst` for 1 cycle → next cycle `note` = 0, `octave` = 3, no `note_off`.
   - Key still held → `note_on` with `note` = 4 seven cycles after `rst` deasserts.
